// File: rtl/answer_timer_pkg.sv
// Shared definitions for the answer timer: FSM state encoding, BCD digit
// width and the largest value the two-digit countdown can hold.
package answer_timer_pkg;

  localparam int BCD_W     = 4;
  localparam int MAX_DIGIT = 9;
  localparam int MAX_VAL   = 99;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  // Non-BCD digit codes (A..F) are treated as 9 so the limit never exceeds 99.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
    return (d > BCD_W'(MAX_DIGIT)) ? BCD_W'(MAX_DIGIT) : d;
  endfunction

endpackage

// File: rtl/answer_timer_bcd_dec2.sv
// Two-digit BCD decrement, purely combinational.
// Ports:
//   tens, ones         : current BCD value
//   dec_tens, dec_ones : value minus one; holds at 00 when the input is 00
//   zero               : input value is 00
module bcd_dec2
  import answer_timer_pkg::*;
(
  input  logic [BCD_W-1:0] tens,
  input  logic [BCD_W-1:0] ones,
  output logic [BCD_W-1:0] dec_tens,
  output logic [BCD_W-1:0] dec_ones,
  output logic             zero
);

  always_comb begin
    zero     = (tens == '0) && (ones == '0);
    dec_tens = tens;
    dec_ones = ones;
    if (!zero) begin
      if (ones == '0) begin
        // borrow from the tens digit
        dec_ones = BCD_W'(MAX_DIGIT);
        dec_tens = tens - BCD_W'(1);
      end else begin
        dec_ones = ones - BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/answer_timer.sv
// Answer countdown timer: loads a two-digit BCD limit, counts it down once
// per 1 s tick, supports pause/abort, and holds an expired flag until
// acknowledged.
// Ports:
//   clk, rst (sync, active-low)
//   timeout1s           : 1 s tick pulse
//   start, load_tens/ones : load limit and begin counting
//   pause (level), abort, ack
//   rem_tens/rem_ones   : remaining seconds (registered BCD)
//   busy, warn, expired : status decoded from registered state/rem
//
// state     | meaning
// ----------+---------------------------------------------
// S_IDLE    | no countdown, rem = 00
// S_RUN     | counting down on each tick
// S_PAUSE   | countdown frozen while pause is high
// S_EXPIRED | count reached 00, waiting for ack/abort/start
module answer_timer
  import answer_timer_pkg::*;
#(
  parameter int WARN_SECS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timeout1s,
  input  logic             start,
  input  logic [BCD_W-1:0] load_tens,
  input  logic [BCD_W-1:0] load_ones,
  input  logic             pause,
  input  logic             abort,
  input  logic             ack,
  output logic [BCD_W-1:0] rem_tens,
  output logic [BCD_W-1:0] rem_ones,
  output logic             busy,
  output logic             warn,
  output logic             expired
);

  state_t           state, state_nxt;
  logic [BCD_W-1:0] tens_nxt, ones_nxt;
  logic [BCD_W-1:0] dec_tens, dec_ones;
  logic [BCD_W-1:0] ld_tens, ld_ones;
  logic             rem_zero;

  bcd_dec2 u_dec (
    .tens     (rem_tens),
    .ones     (rem_ones),
    .dec_tens (dec_tens),
    .dec_ones (dec_ones),
    .zero     (rem_zero)
  );

  assign ld_tens = clamp_digit(load_tens);
  assign ld_ones = clamp_digit(load_ones);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      rem_tens <= '0;
      rem_ones <= '0;
    end else begin
      state    <= state_nxt;
      rem_tens <= tens_nxt;
      rem_ones <= ones_nxt;
    end
  end

  // Priority abort > start > ack > tick > pause; losers are simply dropped.
  always_comb begin
    state_nxt = state;
    tens_nxt  = rem_tens;
    ones_nxt  = rem_ones;
    if (abort) begin
      state_nxt = S_IDLE;
      tens_nxt  = '0;
      ones_nxt  = '0;
    end else if (start) begin
      tens_nxt  = ld_tens;
      ones_nxt  = ld_ones;
      state_nxt = ((ld_tens == '0) && (ld_ones == '0)) ? S_EXPIRED : S_RUN;
    end else begin
      unique case (state)
        S_EXPIRED: begin
          if (ack) begin
            state_nxt = S_IDLE;
            tens_nxt  = '0;
            ones_nxt  = '0;
          end
        end
        S_RUN: begin
          if (timeout1s && !rem_zero) begin
            tens_nxt = dec_tens;
            ones_nxt = dec_ones;
            if ((dec_tens == '0) && (dec_ones == '0)) state_nxt = S_EXPIRED;
          end else if (pause) begin
            state_nxt = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (!pause) state_nxt = S_RUN;
        end
        default: ;
      endcase
    end
  end

  // WARN_SECS is a single digit, so the warn window lies entirely in the ones digit.
  assign busy    = (state == S_RUN) || (state == S_PAUSE);
  assign expired = (state == S_EXPIRED);
  assign warn    = busy && (rem_tens == '0) && (rem_ones != '0) &&
                   (rem_ones <= BCD_W'(WARN_SECS));

endmodule

// File: tb/tb_answer_timer.sv
module tb_answer_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       timeout1s, start, pause, abort, ack;
  logic [3:0] load_tens, load_ones;
  logic [3:0] rem_tens, rem_ones;
  logic       busy, warn, expired;

  int checks   = 0;
  int failures = 0;

  answer_timer #(.WARN_SECS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .timeout1s (timeout1s),
    .start     (start),
    .load_tens (load_tens),
    .load_ones (load_ones),
    .pause     (pause),
    .abort     (abort),
    .ack       (ack),
    .rem_tens  (rem_tens),
    .rem_ones  (rem_ones),
    .busy      (busy),
    .warn      (warn),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge; pulse inputs are cleared afterwards, pause is a level.
  task automatic cycle();
    @(posedge clk);
    #1;
    timeout1s = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    ack       = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [7:0] rem,
                           input logic b, input logic w, input logic e);
    check({tag, "_rem"}, {rem_tens, rem_ones}, rem);
    check({tag, "_busy"}, {7'd0, busy}, {7'd0, b});
    check({tag, "_warn"}, {7'd0, warn}, {7'd0, w});
    check({tag, "_exp"}, {7'd0, expired}, {7'd0, e});
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    rst = 1'b0; timeout1s = 0; start = 0; pause = 0; abort = 0; ack = 0;
    load_tens = 0; load_ones = 0;
    cycle(); cycle();
    check_all("reset", 8'h00, 0, 0, 0);
    rst = 1'b1;
    cycle();

    // load 12 and run it down to expiry
    load_tens = 4'd1; load_ones = 4'd2; start = 1; cycle();
    check_all("s1_load", 8'h12, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      int v;
      v = 12 - i;
      timeout1s = 1; cycle();
      check_all($sformatf("s1_t%0d", i), to_bcd(v), (v != 0),
                (v != 0) && (v <= 5), (v == 0));
    end
    timeout1s = 1; cycle();
    check_all("s1_tick_expired", 8'h00, 0, 0, 1);
    ack = 1; cycle();
    check_all("s1_ack", 8'h00, 0, 0, 0);

    // pause holds the count
    load_tens = 4'd2; load_ones = 4'd0; start = 1; cycle();
    timeout1s = 1; cycle();
    check("s2_19", {rem_tens, rem_ones}, 8'h19);
    pause = 1; cycle();
    for (int i = 0; i < 3; i++) begin
      timeout1s = 1; cycle();
    end
    check_all("s2_paused", 8'h19, 1, 0, 0);
    pause = 0; cycle();
    timeout1s = 1; cycle();
    check_all("s2_18", 8'h18, 1, 0, 0);
    ack = 1; cycle();
    check("s2_ack_ignored", {rem_tens, rem_ones}, 8'h18);

    // zero load goes straight to expired
    load_tens = 4'd0; load_ones = 4'd0; start = 1; cycle();
    check_all("s3_zero", 8'h00, 0, 0, 1);
    ack = 1; cycle();
    check_all("s3_ack", 8'h00, 0, 0, 0);
    load_tens = 4'd0; load_ones = 4'd0; start = 1; cycle();
    load_ones = 4'd3; start = 1; cycle();
    check_all("s3_restart", 8'h03, 1, 1, 0);

    // clamp, then start wins over tick
    load_tens = 4'hF; load_ones = 4'hA; start = 1; cycle();
    check("s4_clamp", {rem_tens, rem_ones}, 8'h99);
    timeout1s = 1; cycle();
    check("s4_98", {rem_tens, rem_ones}, 8'h98);
    load_tens = 4'd4; load_ones = 4'd5; start = 1; timeout1s = 1; cycle();
    check_all("s4_start_tick", 8'h45, 1, 0, 0);

    // abort beats tick
    load_tens = 4'd0; load_ones = 4'd7; start = 1; cycle();
    check_all("s5_07", 8'h07, 1, 0, 0);
    abort = 1; timeout1s = 1; cycle();
    check_all("s5_abort", 8'h00, 0, 0, 0);
    timeout1s = 1; cycle();
    check("s5_idle_tick", {rem_tens, rem_ones}, 8'h00);

    // reset mid-count
    load_tens = 4'd3; load_ones = 4'd3; start = 1; cycle();
    check("s6_33", {rem_tens, rem_ones}, 8'h33);
    rst = 0; timeout1s = 1; cycle();
    check_all("s6_rst", 8'h00, 0, 0, 0);
    rst = 1; timeout1s = 1; cycle();
    check_all("s6_after", 8'h00, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/answer_timer.md
ANSWER_TIMER -- requirements
Module: answer_timer

Interface
REQ-001 Parameter: WARN_SECS, 5, warn threshold in seconds (1..9).
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low (rst==0 resets on the next posedge clk).
REQ-004 timeout1s  input  1  one-cycle 1 s tick from the seconds counter; the block is its consumer.
REQ-005 start  input  1  one-cycle pulse, load the time limit and begin the countdown.
REQ-006 load_tens  input  4  BCD tens digit of the limit.
REQ-007 load_ones  input  4  BCD ones digit of the limit.
REQ-008 pause  input  1  level; while high, the countdown is frozen.
REQ-009 abort  input  1  one-cycle pulse, cancel and return to idle.
REQ-010 ack  input  1  one-cycle pulse, clear the expired condition.
REQ-011 rem_tens  output  4  BCD tens digit of the remaining seconds (registered).
REQ-012 rem_ones  output  4  BCD ones digit of the remaining seconds (registered).
REQ-013 busy  output  1  high in RUN or PAUSE.
REQ-014 warn  output  1  high in RUN/PAUSE when the remaining time is <= WARN_SECS and nonzero.
REQ-015 expired  output  1  level; high in EXPIRED until ack, abort or start.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, PAUSE and EXPIRED, encoded as a 2-bit state register.
REQ-017 start in any state SHALL load rem from load_tens/load_ones on the next edge and enter RUN.
- A loaded digit greater than 9 SHALL be clamped to 9.
REQ-018 If a start loads 00, the next state SHALL be EXPIRED directly, without entering RUN.
REQ-019 In RUN, each timeout1s SHALL decrement rem by 1 in BCD.
- Ones 0 -> 9 with a tens borrow (e.g. 20 -> 19).
- rem SHALL update on the edge sampling the tick; latency is 1 cycle.
REQ-020 A tick in RUN with rem==01 SHALL set rem=00 and enter EXPIRED on the same edge.
REQ-021 In RUN, pause==1 SHALL enter PAUSE.
- In PAUSE, ticks SHALL be ignored and rem SHALL hold.
- pause==0 SHALL return to RUN.
REQ-022 Ticks in IDLE or EXPIRED SHALL be ignored, and rem SHALL hold.
REQ-023 ack in EXPIRED SHALL enter IDLE with rem=00; ack in any other state SHALL be ignored.
REQ-024 abort in any state SHALL enter IDLE with rem=00 and expired=0.
REQ-025 Priority SHALL be reset > abort > start > ack > tick > pause. Lower-priority events in the same cycle SHALL be dropped, not queued.
REQ-026 A start coincident with a tick SHALL load the new value undecremented.
REQ-027 rem SHALL never underflow below 00 and never exceed 99.
REQ-028 busy, warn and expired SHALL be decoded from registered state and rem only, with no input-to-output combinational path.

Reset
REQ-029 While rst==0 at a clock edge, the block SHALL set state=IDLE, rem_tens=0, rem_ones=0, busy=0, warn=0 and expired=0.
REQ-030 Reset mid-count SHALL discard the count; no event SHALL be remembered across reset.

Structure
REQ-031 The state encoding, BCD digit width (4) and max value (99) SHALL live in the shared trainer package.
REQ-032 BCD decrement SHALL be one sub-module, bcd_dec2, with inputs tens/ones and outputs tens/ones/zero. It is combinational and has no clock.
REQ-033 Implementation target: 120-400 lines of RTL in total.

Verification
REQ-034 The following directed scenarios SHALL be covered:
- Load 12, start, 12 ticks -> rem steps 11..01 -> 00; expired=1 on the 12th tick edge; warn=1 from rem=05 through 01.
- Load 20, start, 1 tick -> rem=19; pause high, 3 ticks -> rem stays 19; pause low, 1 tick -> 18.
- Load 00, start -> EXPIRED next cycle, expired=1, busy=0; ack -> IDLE, expired=0.
- Load 0xF/0xA digits -> rem=99; tick coincident with a start of 45 -> rem=45.
- RUN at rem=07, abort coincident with a tick -> IDLE, rem=00; a later tick leaves rem=00.
- rst=0 for 1 cycle during RUN at rem=33 -> all outputs 0 and state IDLE on that edge.
